uart_rx_fifo: RTL and testbench

//  Parametrised UART receiver with 16x oversampling, majority-vote sampling,

---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/uart_rx_fifo.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and the
// baud-tick divider helper used to size the oversampling counter.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  // Rounded so the tick rate lands as close as possible to OVERSAMPLE*baud.
  function automatic int uart_div(input int clk_hz, input int baud);
    return (clk_hz + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: the head entry is visible on rdata_o while
// not empty; a pop is accepted alongside a push even when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign count_o = count_q;
  // Forced to zero when empty so the head port never shows stale data.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling and 3-sample majority vote, feeding a
// show-ahead RX FIFO drained through ready/ack, with sticky error flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 25_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clock25,
  input  logic                            reset_n,
  input  logic                            rx,
  output logic [DATA_BITS-1:0]            rbyte,
  output logic                            ready,
  input  logic                            ack,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            frame_err,
  output logic                            parity_err,
  output logic                            overrun,
  input  logic                            clr_err
);

  localparam int DIV = uart_div(CLK_HZ, BAUD);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = $clog2(DATA_BITS);

  logic [1:0]           sync_q, sync_d;
  logic [DW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [3:0]           s_q, s_d;
  logic [1:0]           samp_q, samp_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_bad_q, par_bad_d;
  rx_state_e            state_q, state_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;

  logic rx_s, tick, mid, maj, start_det, par_exp;
  logic push, pop, fifo_full, fifo_empty;
  logic set_frame, set_parity, set_overrun;

  assign rx_s      = sync_q[1];
  assign tick      = (tick_cnt_q == DW'(DIV - 1));
  assign mid       = tick & (s_q == 4'd9);
  // Samples from s=7 and s=8 are held; the s=9 sample is the live line.
  assign maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign start_det = (state_q == ST_IDLE) & ~rx_s;
  assign par_exp   = (PARITY == PAR_ODD) ? ~(^shreg_q) : ^shreg_q;
  assign ready     = ~fifo_empty;
  assign pop       = ack & ready;

  always_comb begin
    sync_d     = {sync_q[0], rx};
    tick_cnt_d = (start_det || tick) ? '0 : tick_cnt_q + DW'(1);
    s_d        = s_q;
    samp_d     = samp_q;
    if (state_q == ST_IDLE) begin
      s_d = 4'd0;
    end else if (tick) begin
      s_d = s_q + 4'd1;
      if (s_q == 4'd7) samp_d[0] = rx_s;
      if (s_q == 4'd8) samp_d[1] = rx_s;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    par_bad_d   = par_bad_q;
    push        = 1'b0;
    set_frame   = 1'b0;
    set_parity  = 1'b0;
    set_overrun = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (mid) begin
          if (maj) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_d     = '0;
            par_bad_d = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (mid) begin
          shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
          if (bit_q == BW'(DATA_BITS - 1))
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          else
            bit_d = bit_q + BW'(1);
        end
      end
      ST_PARITY: begin
        if (mid) begin
          par_bad_d = (maj != par_exp);
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leaving at the stop-bit midpoint lets a back-to-back start edge be seen.
        if (mid) begin
          state_d = ST_IDLE;
          if (!maj) begin
            set_frame = 1'b1;
            state_d   = ST_BREAK;
          end else if (par_bad_q) begin
            set_parity = 1'b1;
          end else if (fifo_full && !pop) begin
            set_overrun = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign frame_err_d  = set_frame   | (frame_err_q  & ~clr_err);
  assign parity_err_d = set_parity  | (parity_err_q & ~clr_err);
  assign overrun_d    = set_overrun | (overrun_q    & ~clr_err);

  always_ff @(posedge clock25 or negedge reset_n) begin
    if (!reset_n) begin
      sync_q       <= 2'b11;
      tick_cnt_q   <= '0;
      s_q          <= '0;
      samp_q       <= 2'b11;
      bit_q        <= '0;
      shreg_q      <= '0;
      par_bad_q    <= 1'b0;
      state_q      <= ST_IDLE;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      tick_cnt_q   <= tick_cnt_d;
      s_q          <= s_d;
      samp_q       <= samp_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      par_bad_q    <= par_bad_d;
      state_q      <= state_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock25),
    .rst_ni  (reset_n),
    .push_i  (push),
    .wdata_i (shreg_q),
    .pop_i   (pop),
    .rdata_o (rbyte),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 instance against a frame-level queue model,
// plus an even-parity instance for the parity checks.
module tb_uart_rx_fifo;

  localparam int DIV_REF  = (25_000_000 + 8 * 115_200) / (16 * 115_200);
  localparam int BIT_CLKS = 16 * DIV_REF;
  localparam int DEPTH    = 16;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic       rst_n;
  logic       rx_a, ack_a, clr_a, ready_a, ferr_a, perr_a, ovr_a;
  logic [7:0] rbyte_a;
  logic [4:0] count_a;
  logic       rx_b, ack_b, clr_b, ready_b, ferr_b, perr_b, ovr_b;
  logic [7:0] rbyte_b;
  logic [4:0] count_b;

  uart_rx_fifo dut_a (
    .clock25(clk), .reset_n(rst_n), .rx(rx_a), .rbyte(rbyte_a), .ready(ready_a),
    .ack(ack_a), .count(count_a), .frame_err(ferr_a), .parity_err(perr_a),
    .overrun(ovr_a), .clr_err(clr_a)
  );

  uart_rx_fifo #(.PARITY(2)) dut_b (
    .clock25(clk), .reset_n(rst_n), .rx(rx_b), .rbyte(rbyte_b), .ready(ready_b),
    .ack(ack_b), .count(count_b), .frame_err(ferr_b), .parity_err(perr_b),
    .overrun(ovr_b), .clr_err(clr_b)
  );

  logic [7:0] exp_q [$];
  bit         exp_ferr, exp_perr, exp_ovr;
  int         checks   = 0;
  int         failures = 0;
  int         commit_k;
  logic [7:0] data, first5, par_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame-level outcome for the 8N1 receiver.
  task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit popped);
    if (!stop_ok) exp_ferr = 1'b1;
    else if (exp_q.size() == DEPTH && !popped) exp_ovr = 1'b1;
    else begin
      if (popped && exp_q.size() != 0) void'(exp_q.pop_front());
      exp_q.push_back(d);
    end
  endtask

  task automatic check_a(input string tag);
    check({tag, ".ready"}, 32'(ready_a), 32'(exp_q.size() != 0));
    check({tag, ".count"}, 32'(count_a), 32'(exp_q.size()));
    if (exp_q.size() != 0) check({tag, ".rbyte"}, 32'(rbyte_a), 32'(exp_q[0]));
    check({tag, ".frame_err"}, 32'(ferr_a), 32'(exp_ferr));
    check({tag, ".parity_err"}, 32'(perr_a), 32'(exp_perr));
    check({tag, ".overrun"}, 32'(ovr_a), 32'(exp_ovr));
  endtask

  task automatic drive_bit(input bit sel, input bit v);
    if (sel) rx_b = v; else rx_a = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                            input bit par_bit, input bit stop_bit);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (has_par) drive_bit(sel, par_bit);
    drive_bit(sel, stop_bit);
  endtask

  task automatic pulse_ack_a();
    check("drain.rbyte", 32'(rbyte_a), 32'(exp_q[0]));
    ack_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
    void'(exp_q.pop_front());
    @(negedge clk);
  endtask

  task automatic pulse_clr(input bit sel);
    if (sel) clr_b = 1'b1; else clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    clr_b = 1'b0;
    if (!sel) begin exp_ferr = 0; exp_perr = 0; exp_ovr = 0; end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_a = 1'b1; ack_a = 1'b0; clr_a = 1'b0;
    rx_b = 1'b1; ack_b = 1'b0; clr_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.rbyte", 32'(rbyte_a), 32'h0);
    check_a("reset");
    check("reset_b.ready", 32'(ready_b), 32'h0);
    check("reset_b.count", 32'(count_b), 32'h0);
    rst_n = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);

    // 1: two back-to-back bytes; measure when ready rises for the first one
    fork
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        commit_k = 0;
        while (!ready_a && commit_k < 11 * BIT_CLKS) begin
          @(negedge clk);
          commit_k++;
        end
      end
    join
    model_frame(8'hA5, 1'b1, 1'b0);
    check("t1.ready_after_stop_mid", 32'(commit_k > 9 * BIT_CLKS + BIT_CLKS / 2), 32'h1);
    check("t1.ready_within_stop", 32'(commit_k < 10 * BIT_CLKS), 32'h1);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    model_frame(8'h3C, 1'b1, 1'b0);
    check_a("t1.two");
    pulse_ack_a();
    check_a("t1.one");
    pulse_ack_a();
    check_a("t1.empty");

    // 2: short low glitch while idle, then a random byte proves the FSM recovered
    rx_a = 1'b0;
    repeat (5) @(negedge clk);
    rx_a = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check_a("t2.glitch");
    data = 8'($urandom_range(0, 255));
    send_frame(1'b0, data, 1'b0, 1'b0, 1'b1);
    model_frame(data, 1'b1, 1'b0);
    check_a("t2.after");

    // 3: even parity instance
    send_frame(1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    check("t3.parity_err", 32'(perr_b), 32'h1);
    check("t3.count", 32'(count_b), 32'h0);
    check("t3.frame_err", 32'(ferr_b), 32'h0);
    pulse_clr(1'b1);
    check("t3.cleared", 32'(perr_b), 32'h0);
    par_data = 8'($urandom_range(0, 255));
    send_frame(1'b1, par_data, 1'b1, ^par_data, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    check("t3.good.count", 32'(count_b), 32'h1);
    check("t3.good.rbyte", 32'(rbyte_b), 32'(par_data));
    check("t3.good.parity_err", 32'(perr_b), 32'h0);

    // 4: line held low for three frame times gives a single frame error
    rx_a = 1'b0;
    repeat (10 * BIT_CLKS) @(negedge clk);
    model_frame(8'h00, 1'b0, 1'b0);
    check_a("t4.first");
    pulse_clr(1'b0);
    repeat (20 * BIT_CLKS) @(negedge clk);
    check_a("t4.held");
    rx_a = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    model_frame(8'h55, 1'b1, 1'b0);
    check_a("t4.after");

    // 5: fill the FIFO with random bytes, overflow by one, then pop on the commit cycle
    while (exp_q.size() != 0) pulse_ack_a();
    for (int n = 0; n < 17; n++) begin
      data = 8'($urandom_range(0, 255));
      if (n == 0) first5 = data;
      send_frame(1'b0, data, 1'b0, 1'b0, 1'b1);
      model_frame(data, 1'b1, 1'b0);
    end
    check("t5.head_is_first", 32'(rbyte_a), 32'(first5));
    check_a("t5.overrun");
    pulse_clr(1'b0);
    check_a("t5.cleared");
    data = 8'($urandom_range(0, 255));
    fork
      send_frame(1'b0, data, 1'b0, 1'b0, 1'b1);
      begin
        repeat (commit_k - 1) @(negedge clk);
        ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
      end
    join
    model_frame(data, 1'b1, 1'b1);
    check_a("t5.ack_at_commit");
    for (int n = 0; n < 8; n++) pulse_ack_a();
    check_a("t5.half");

    // 6: asynchronous reset in the middle of a data bit
    data = 8'h7E;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, data[i]);
    rx_a = data[3];
    repeat (BIT_CLKS / 2) @(negedge clk);
    #5 rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_ferr = 0; exp_perr = 0; exp_ovr = 0;
    check("t6.rbyte", 32'(rbyte_a), 32'h0);
    check_a("t6.async");
    rx_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    send_frame(1'b0, 8'h7E, 1'b0, 1'b0, 1'b1);
    model_frame(8'h7E, 1'b1, 1'b0);
    check_a("t6.after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
